data_memory_responder: RTL

Memory-side responder for the core's `Bundle::MemoryIn`/`Bundle::MemoryOut` request/response interface. It serves instruction or data requests from the control path. It owns a word-organised 32-bit SRAM array and performs byte, halfword and word reads and writes with lane steering and load sign/zero extension. It returns one `res_valid` pulse per request after a parameterised latency, which drives the core's `cmiss_stall` logic.

---
 rtl/data_memory_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-organised SRAM responder with byte/halfword/word lane steering and fixed-latency response.
// Define DATA_MEMORY_RESPONDER_MISALIGN_TRAP_EN to trap misaligned or unknown-type requests with res_err.
module data_memory_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_fcn,
   input  logic [2:0]  req_typ,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_err
);
   localparam logic [2:0] MT_W = 3'd3;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_ready, r_res_valid, r_err;
   logic [31:0]           r_data;
   logic [31:0]           r_mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [2:0]            w_typ;
   logic [1:0]            w_sz, w_lane;
   logic                  w_legal, w_err, w_acc, w_sgn, w_unused;
   logic [31:0]           w_word, w_sh, w_rdata, w_wword;
   logic [3:0]            w_be;
   assign w_unused = &{1'b0, req_addr[31:ADDR_WIDTH+2]};
   assign w_idx    = req_addr[ADDR_WIDTH+1:2];
   assign w_legal  = req_typ[1:0] != 2'b00;
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_TRAP_EN
   assign w_typ  = req_typ;
   assign w_lane = req_addr[1:0];
   assign w_err  = !w_legal || (w_sz == 2'b10 && req_addr[0]) || (w_sz == 2'b11 && req_addr[1:0] != 2'b00);
`else
   assign w_typ  = w_legal ? req_typ : MT_W;
   assign w_lane = w_sz == 2'b11 ? 2'b00 : w_sz == 2'b10 ? {req_addr[1], 1'b0} : req_addr[1:0];
   assign w_err  = 1'b0;
`endif
   assign w_sz    = w_typ[1:0];
   assign w_sgn   = !w_typ[2];
   assign w_acc   = !reset && r_state == S_IDLE && req_valid;
   assign w_word  = r_mem[w_idx];
   assign w_sh    = w_word >> {w_lane, 3'b000};
   assign w_rdata = w_sz == 2'b01 ? {{24{w_sgn & w_sh[7]}}, w_sh[7:0]}
                  : w_sz == 2'b10 ? {{16{w_sgn & w_sh[15]}}, w_sh[15:0]} : w_word;
   assign w_wword = w_sz == 2'b01 ? {4{req_wdata[7:0]}} : w_sz == 2'b10 ? {2{req_wdata[15:0]}} : req_wdata;
   assign w_be    = w_sz == 2'b01 ? 4'b0001 << w_lane : w_sz == 2'b10 ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   // Stores commit at the accept edge, so a later reset cannot undo them.
   always_ff @(posedge clk)
      if (w_acc && req_fcn && !w_err)
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_ready     <= 1'b1;
         r_res_valid <= 1'b0;
         r_data      <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_state     <= LATENCY == 1 ? S_RESP : S_WAIT;
               r_cnt       <= LATENCY == 1 ? 4'd0 : 4'(LATENCY - 2);
               r_ready     <= 1'b0;
               r_res_valid <= LATENCY == 1;
               r_data      <= (req_fcn || w_err) ? 32'd0 : w_rdata;
               r_err       <= w_err;
            end
            S_WAIT: if (r_cnt == 4'd0) begin
               r_state     <= S_RESP;
               r_res_valid <= 1'b1;
            end else r_cnt <= r_cnt - 4'd1;
            S_RESP: begin
               r_state     <= S_IDLE;
               r_ready     <= 1'b1;
               r_res_valid <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign req_ready = r_ready;
   assign res_valid = r_res_valid;
   assign res_data  = r_data;
   assign res_err   = r_err;
endmodule
